bot_velocity_dispatcher: RTL and testbench
==========================================

// Module: bot_velocity_dispatcher
// PURPOSE
//  Parametrised, synthesisable velocity broadcaster for the synchronisation layer.
//  On each update request it snapshots NUM_BOTS (vx,vy) fixed-point pairs.
//  It then visits the bots in index order, with a programmable stagger between visits.
//  A bot receives its pair only if it reports ready (has consumed its previous pair); otherwise it is skipped.
//  Supports N bots, any width and a stagger-or-burst mode, and queues one request that arrives mid-sweep.
// PARAMETERS
//  NUM_BOTS     3    number of bot channels (>=1)
//  VEL_W        16   velocity word width, two's-complement fixed point
//  FRAC_BITS    11   fractional bits of VEL_W (informational; data passed unmodified)
//  SLOT_CYCLES  100  idle cycles before each bot visit in stagger mode (>=1)
//  BURST_MODE   0    0: stagger by SLOT_CYCLES; 1: visit bots on consecutive cycles
// PORTS
//  clk          in   1                 system clock, rising edge
//  rst_n        in   1                 asynchronous active-low reset
//  update_req   in   1                 1-cycle pulse: snapshot inputs, start sweep
//  vx_in        in   NUM_BOTS*VEL_W    packed vx, bot k at [k*VEL_W +: VEL_W]
//  vy_in        in   NUM_BOTS*VEL_W    packed vy, same packing
//  bot_ready    in   NUM_BOTS          bot k has consumed its last pair (the 'r' flag)
//  wr_valid     out  NUM_BOTS          1-cycle one-hot write strobe to bot k
//  wr_vx        out  VEL_W             shared vx data, valid while wr_valid!=0
//  wr_vy        out  VEL_W             shared vy data, valid while wr_valid!=0
//  busy         out  1                 sweep in progress
//  done         out  1                 1-cycle pulse when a sweep completes
//  skipped      out  NUM_BOTS          bots not ready in last completed sweep
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - All outputs are 0.
//   - Shadow registers, pending flag, bot index and slot counter are cleared; FSM goes to IDLE.
//   - Reset mid-sweep aborts the sweep immediately; no further wr_valid is issued.
//  FSM states: IDLE, WAIT, VISIT, FIN.
//   - IDLE: on update_req, latch all vx_in/vy_in into shadows, idx<=0, busy<=1.
//     Next state is WAIT (BURST_MODE=0) or VISIT (BURST_MODE=1).
//   - WAIT: slot counter counts 1..SLOT_CYCLES, then go to VISIT.
//     The counter is $clog2(SLOT_CYCLES+1) bits wide and is cleared on every WAIT entry.
//   - VISIT (exactly 1 cycle), sampling bot_ready[idx]:
//     - If 1: next cycle wr_valid[idx]=1 with wr_vx/wr_vy = shadow[idx], and the working skip bit is cleared.
//     - If 0: no strobe, and the working skip bit is set.
//     - If idx==NUM_BOTS-1: go to FIN. Otherwise idx++ and go to WAIT (or VISIT in burst mode).
//   - FIN (1 cycle): done=1 and skipped<=working mask.
//     - If pending is set: clear it, re-snapshot inputs and start a new sweep; busy stays 1.
//     - Otherwise busy<=0 and go to IDLE.
//  Outputs and latency:
//   - wr_valid is registered and at most one bit is set per cycle.
//   - wr_vx/wr_vy are held at the last written value between strobes.
//   - First strobe comes SLOT_CYCLES+2 cycles after update_req (stagger) or 2 cycles after (burst).
//  update_req while busy sets pending (one deep).
//   - Further requests before FIN are merged into the same pending flag.
//   - update_req in the FIN cycle also sets pending.
//  Inputs change only at snapshot time; edits to vx_in/vy_in during a sweep have no effect.
//  skipped is updated only in FIN; it holds across IDLE and is cleared by reset only.
//  Data is passed bit-exact; no scaling, saturation or sign handling is performed.
// TESTING
//  T1 reset:
//   - Stimulus: rst_n low mid-sweep (wait state, bot 1).
//   - Required: all outputs 0 asynchronously; no strobe after release until a new update_req.
//  T2 all ready, stagger, SLOT_CYCLES=4, NUM_BOTS=3:
//   - Stimulus: bot0 vx=16'h0800 (1.0), vy=16'h0002.
//   - Required: wr_valid 001/010/100 at cycles 6/11/16 after the req; done at 17; skipped=000.
//  T3 bot1 not ready:
//   - Required: only bits 0 and 2 strobe; skipped=3'b010.
//   - Next sweep with bot1 ready: skipped=000.
//  T4 snapshot:
//   - Stimulus: change vx_in for bot2 to 16'hF800 (-1.0) one cycle after the req.
//   - Required: bot2 still gets the old value; the next sweep delivers 16'hF800.
//  T5 pending:
//   - Stimulus: 3 update_req pulses during one sweep.
//   - Required: exactly one extra sweep; it starts the cycle after done; busy never drops between sweeps.
//  T6 BURST_MODE=1, NUM_BOTS=5, VEL_W=24:
//   - Required: strobes on 5 consecutive cycles starting req+2; packing correct for k=4.

Source files
------------

// File: rtl/bot_velocity_dispatcher.sv
// Velocity broadcaster: snapshots NUM_BOTS (vx,vy) pairs on update_req and
// writes them to ready bots one at a time, staggered or back-to-back.
// Latency: first strobe SLOT_CYCLES+2 cycles after update_req (burst: 2).
// Backpressure: per-bot ready; a bot not ready at its visit is skipped
// and reported; one request arriving mid-sweep is queued.
// Ports:
//   update_req        start pulse (queued as pending while busy)
//   vx_in/vy_in       packed per-bot velocities, bot k at [k*VEL_W +: VEL_W]
//   bot_ready         per-bot "consumed previous pair" flag
//   wr_valid          one-hot write strobe, wr_vx/wr_vy shared data
//   busy/done/skipped sweep status; skipped holds the last sweep's miss mask
module bot_velocity_dispatcher #(
  parameter int NUM_BOTS    = 3,
  parameter int VEL_W       = 16,
  parameter int FRAC_BITS   = 11,
  parameter int SLOT_CYCLES = 100,
  parameter int BURST_MODE  = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      update_req,
  input  logic [NUM_BOTS*VEL_W-1:0] vx_in,
  input  logic [NUM_BOTS*VEL_W-1:0] vy_in,
  input  logic [NUM_BOTS-1:0]       bot_ready,
  output logic [NUM_BOTS-1:0]       wr_valid,
  output logic [VEL_W-1:0]          wr_vx,
  output logic [VEL_W-1:0]          wr_vy,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_BOTS-1:0]       skipped
);

  localparam int IW = (NUM_BOTS > 1) ? $clog2(NUM_BOTS) : 1;
  localparam int CW = $clog2(SLOT_CYCLES + 1);

  if (NUM_BOTS < 1) begin : g_bad_num_bots
    $error("NUM_BOTS must be at least 1");
  end
  if (SLOT_CYCLES < 1) begin : g_bad_slot_cycles
    $error("SLOT_CYCLES must be at least 1");
  end
  if (FRAC_BITS < 0 || FRAC_BITS >= VEL_W) begin : g_bad_frac_bits
    $error("FRAC_BITS must lie within VEL_W");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VISIT, S_FIN} state_t;

  state_t                    state_q, state_d;
  logic [NUM_BOTS*VEL_W-1:0] shx_q, shx_d, shy_q, shy_d;
  logic                      pend_q, pend_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [CW-1:0]             cnt_q, cnt_d, cnt_inc;
  logic [NUM_BOTS-1:0]       mask_q, mask_d;
  logic [NUM_BOTS-1:0]       wr_valid_d, skipped_d;
  logic [VEL_W-1:0]          wr_vx_d, wr_vy_d;
  logic                      busy_d, done_d, start;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    shx_d      = shx_q;
    shy_d      = shy_q;
    pend_d     = pend_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    wr_valid_d = '0;
    wr_vx_d    = wr_vx;
    wr_vy_d    = wr_vy;
    busy_d     = busy;
    done_d     = 1'b0;
    skipped_d  = skipped;
    start      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A pending flag can survive into IDLE when a request lands in FIN
        // with nothing already queued.
        if (update_req || pend_q) begin
          start  = 1'b1;
          pend_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (update_req) pend_d = 1'b1;
        cnt_d = cnt_inc;
        if (cnt_inc == CW'(SLOT_CYCLES)) state_d = S_VISIT;
      end
      S_VISIT: begin
        if (update_req) pend_d = 1'b1;
        if (bot_ready[idx_q]) begin
          wr_valid_d[idx_q] = 1'b1;
          wr_vx_d           = shx_q[int'(idx_q)*VEL_W +: VEL_W];
          wr_vy_d           = shy_q[int'(idx_q)*VEL_W +: VEL_W];
          mask_d[idx_q]     = 1'b0;
        end else begin
          mask_d[idx_q]     = 1'b1;
        end
        if (idx_q == IW'(NUM_BOTS - 1)) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          cnt_d   = '0;
          state_d = (BURST_MODE != 0) ? S_VISIT : S_WAIT;
        end
      end
      S_FIN: begin
        done_d    = 1'b1;
        skipped_d = mask_q;
        // The queued request is consumed here; a request in this very cycle
        // becomes the next pending one.
        pend_d    = update_req;
        if (pend_q) begin
          start = 1'b1;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      shx_d   = vx_in;
      shy_d   = vy_in;
      idx_d   = '0;
      cnt_d   = '0;
      mask_d  = '0;
      busy_d  = 1'b1;
      state_d = (BURST_MODE != 0) ? S_VISIT : S_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shx_q    <= '0;
      shy_q    <= '0;
      pend_q   <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      wr_valid <= '0;
      wr_vx    <= '0;
      wr_vy    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      skipped  <= '0;
    end else begin
      state_q  <= state_d;
      shx_q    <= shx_d;
      shy_q    <= shy_d;
      pend_q   <= pend_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      wr_valid <= wr_valid_d;
      wr_vx    <= wr_vx_d;
      wr_vy    <= wr_vy_d;
      busy     <= busy_d;
      done     <= done_d;
      skipped  <= skipped_d;
    end
  end

endmodule

// File: tb/tb_bot_velocity_dispatcher.sv
module tb_bot_velocity_dispatcher;

  localparam int N    = 3;
  localparam int W    = 16;
  localparam int SLOT = 4;
  localparam int P    = SLOT + 1;   // cycles per bot slot in stagger mode
  localparam int SW   = N * P;      // sweep length up to the last VISIT
  localparam int NB   = 5;
  localparam int WB   = 24;

  logic              clk, rst_n;
  logic              update_req;
  logic [N*W-1:0]    vx_in, vy_in;
  logic [N-1:0]      bot_ready;
  logic [N-1:0]      wr_valid;
  logic [W-1:0]      wr_vx, wr_vy;
  logic              busy, done;
  logic [N-1:0]      skipped;

  logic              upd_b;
  logic [NB*WB-1:0]  vxb, vyb;
  logic [NB-1:0]     rdy_b;
  logic [NB-1:0]     wv_b;
  logic [WB-1:0]     wvx_b, wvy_b;
  logic              busy_b, done_b;
  logic [NB-1:0]     skip_b;

  int                checks, failures;
  logic [W-1:0]      exp_vx, exp_vy;
  logic [N-1:0]      exp_skip;

  typedef struct {
    int             s;
    logic [N*W-1:0] sx;
    logic [N*W-1:0] sy;
  } sweep_t;

  bot_velocity_dispatcher #(.NUM_BOTS(N), .VEL_W(W), .FRAC_BITS(11),
                            .SLOT_CYCLES(SLOT), .BURST_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .update_req(update_req),
    .vx_in(vx_in), .vy_in(vy_in), .bot_ready(bot_ready),
    .wr_valid(wr_valid), .wr_vx(wr_vx), .wr_vy(wr_vy),
    .busy(busy), .done(done), .skipped(skipped));

  bot_velocity_dispatcher #(.NUM_BOTS(NB), .VEL_W(WB), .FRAC_BITS(11),
                            .SLOT_CYCLES(SLOT), .BURST_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .update_req(upd_b),
    .vx_in(vxb), .vy_in(vyb), .bot_ready(rdy_b),
    .wr_valid(wv_b), .wr_vx(wvx_b), .wr_vy(wvy_b),
    .busy(busy_b), .done(done_b), .skipped(skip_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs len cycles starting with cycle 0. The reference model tracks sweeps
  // as (start cycle, input snapshot) and derives every strobe from slot timing:
  // bot k strobes at start+(k+1)*P+1, done at start+SW+2.
  task automatic run_scn(input string nm, input int len, input logic [63:0] req_mask,
                         input int chg_at, input logic [W-1:0] chg_val);
    int             cur, d;
    bit             pend, ed, eb;
    sweep_t         q[$];
    sweep_t         t;
    logic [N-1:0]   ev;
    logic [N*W-1:0] sx_l, sy_l;
    cur  = -1;
    pend = 0;
    for (int c = 0; c < len; c++) begin
      update_req = req_mask[c];
      if (c == chg_at) vx_in[2*W +: W] = chg_val;
      if (cur < 0) begin
        if (req_mask[c] || pend) begin
          cur = c; pend = 0;
          t.s = c; t.sx = vx_in; t.sy = vy_in; q.push_back(t);
        end
      end else if (c == cur + SW + 1) begin
        if (pend) begin
          cur = c;
          t.s = c; t.sx = vx_in; t.sy = vy_in; q.push_back(t);
        end else begin
          cur = -1;
        end
        pend = req_mask[c];
      end else if (req_mask[c]) begin
        pend = 1;
      end

      @(negedge clk);
      ev = '0; ed = 0; eb = 0;
      foreach (q[i]) begin
        d    = c - q[i].s;
        sx_l = q[i].sx;
        sy_l = q[i].sy;
        if (d >= 1 && d <= SW + 1) eb = 1;
        if (d == SW + 2) ed = 1;
        for (int k = 0; k < N; k++) begin
          if (bot_ready[k] && d == (k + 1) * P + 1) begin
            ev[k]  = 1'b1;
            exp_vx = sx_l[k*W +: W];
            exp_vy = sy_l[k*W +: W];
          end
        end
      end
      if (ed) exp_skip = ~bot_ready;

      checks += 6;
      if (wr_valid !== ev) begin
        failures++; $display("FAIL %s c=%0d wr_valid got=%b exp=%b", nm, c, wr_valid, ev);
      end
      if (busy !== eb) begin
        failures++; $display("FAIL %s c=%0d busy got=%b exp=%b", nm, c, busy, eb);
      end
      if (done !== ed) begin
        failures++; $display("FAIL %s c=%0d done got=%b exp=%b", nm, c, done, ed);
      end
      if (skipped !== exp_skip) begin
        failures++; $display("FAIL %s c=%0d skipped got=%b exp=%b", nm, c, skipped, exp_skip);
      end
      if (wr_vx !== exp_vx) begin
        failures++; $display("FAIL %s c=%0d wr_vx got=%h exp=%h", nm, c, wr_vx, exp_vx);
      end
      if (wr_vy !== exp_vy) begin
        failures++; $display("FAIL %s c=%0d wr_vy got=%h exp=%h", nm, c, wr_vy, exp_vy);
      end
      tick();
    end
    update_req = 1'b0;
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < N; k++) begin
      vx_in[k*W +: W] = W'($urandom);
      vy_in[k*W +: W] = W'($urandom);
    end
  endtask

  task automatic test_reset_init();
    rst_n = 1'b0; update_req = 1'b0; upd_b = 1'b0;
    vx_in = '0; vy_in = '0; bot_ready = '1;
    vxb = '0; vyb = '0; rdy_b = '1;
    exp_vx = '0; exp_vy = '0; exp_skip = '0;
    repeat (3) @(posedge clk);
    #1;
    checks += 2;
    if ({wr_valid, wr_vx, wr_vy, busy, done, skipped} !== '0) begin
      failures++; $display("FAIL reset_init outputs got=%h exp=0",
                           {wr_valid, wr_vx, wr_vy, busy, done, skipped});
    end
    if ({wv_b, wvx_b, wvy_b, busy_b, done_b, skip_b} !== '0) begin
      failures++; $display("FAIL reset_init_burst outputs got=%h exp=0",
                           {wv_b, wvx_b, wvy_b, busy_b, done_b, skip_b});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_all_ready();
    rand_inputs();
    vx_in[0 +: W] = 16'h0800;
    vy_in[0 +: W] = 16'h0002;
    bot_ready = 3'b111;
    run_scn("all_ready", 22, 64'h1, -1, '0);
  endtask

  task automatic test_not_ready();
    rand_inputs();
    bot_ready = 3'b101;
    run_scn("bot1_not_ready", 22, 64'h1, -1, '0);
    bot_ready = 3'b111;
    run_scn("bot1_ready_again", 22, 64'h1, -1, '0);
  endtask

  task automatic test_snapshot();
    rand_inputs();
    vx_in[2*W +: W] = 16'h1234;
    bot_ready = 3'b111;
    run_scn("snapshot_old", 22, 64'h1, 1, 16'hF800);
    run_scn("snapshot_new", 22, 64'h1, -1, '0);
  endtask

  task automatic test_pending();
    logic [63:0] m;
    rand_inputs();
    bot_ready = 3'b111;
    m = '0; m[0] = 1'b1; m[3] = 1'b1; m[7] = 1'b1; m[12] = 1'b1;
    run_scn("pending_merge", 50, m, -1, '0);
  endtask

  task automatic test_random();
    logic [63:0] m;
    for (int it = 0; it < 6; it++) begin
      rand_inputs();
      bot_ready = N'($urandom);
      m = 64'h1;
      if ($urandom_range(1, 0) == 1) m[$urandom_range(15, 2)] = 1'b1;
      run_scn("random", 40, m, -1, '0);
    end
  endtask

  task automatic test_reset_mid();
    rand_inputs();
    bot_ready = 3'b111;
    update_req = 1'b1;
    tick();
    update_req = 1'b0;
    repeat (7) tick();          // cycle 8: waiting ahead of bot 1's visit
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_valid, wr_vx, wr_vy, busy, done, skipped} !== '0) begin
      failures++; $display("FAIL reset_mid async outputs got=%h exp=0",
                           {wr_valid, wr_vx, wr_vy, busy, done, skipped});
    end
    exp_vx = '0; exp_vy = '0; exp_skip = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if ({wr_valid, busy, done} !== '0) begin
        failures++; $display("FAIL reset_mid quiet c=%0d wr_valid/busy/done got=%b exp=0",
                             c, {wr_valid, busy, done});
      end
      tick();
    end
    run_scn("after_reset", 22, 64'h1, -1, '0);
  endtask

  task automatic test_burst(input string nm, input logic [NB-1:0] rdy);
    logic [NB*WB-1:0] sx, sy;
    logic [NB-1:0]    ev;
    for (int k = 0; k < NB; k++) begin
      vxb[k*WB +: WB] = WB'($urandom);
      vyb[k*WB +: WB] = WB'($urandom);
    end
    vxb[4*WB +: WB] = 24'h800001;
    vyb[4*WB +: WB] = 24'hABCDEF;
    rdy_b = rdy;
    upd_b = 1'b1;
    sx = vxb; sy = vyb;
    tick();
    upd_b = 1'b0;
    vxb = ~vxb;
    vyb = ~vyb;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      ev = '0;
      if (c >= 2 && c <= NB + 1 && rdy[c-2]) ev[c-2] = 1'b1;
      checks += 4;
      if (wv_b !== ev) begin
        failures++; $display("FAIL %s c=%0d wr_valid got=%b exp=%b", nm, c, wv_b, ev);
      end
      if (done_b !== (c == NB + 2)) begin
        failures++; $display("FAIL %s c=%0d done got=%b exp=%b", nm, c, done_b, c == NB + 2);
      end
      if (busy_b !== (c <= NB + 1)) begin
        failures++; $display("FAIL %s c=%0d busy got=%b exp=%b", nm, c, busy_b, c <= NB + 1);
      end
      if (c >= NB + 2 && skip_b !== ~rdy) begin
        failures++; $display("FAIL %s c=%0d skipped got=%b exp=%b", nm, c, skip_b, ~rdy);
      end
      if (ev != '0) begin
        checks += 2;
        if (wvx_b !== sx[(c-2)*WB +: WB]) begin
          failures++; $display("FAIL %s c=%0d wr_vx got=%h exp=%h", nm, c, wvx_b, sx[(c-2)*WB +: WB]);
        end
        if (wvy_b !== sy[(c-2)*WB +: WB]) begin
          failures++; $display("FAIL %s c=%0d wr_vy got=%h exp=%h", nm, c, wvy_b, sy[(c-2)*WB +: WB]);
        end
      end
      tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset_init();
    test_all_ready();
    test_not_ready();
    test_snapshot();
    test_pending();
    test_random();
    test_reset_mid();
    test_burst("burst_all", 5'b11111);
    test_burst("burst_rand", NB'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
